// File: rtl/io_bus_arbiter_pkg.sv
// Shared bus widths, control encodings and arbiter state encodings.
// The IO_BUS_WIDTH_* macros may be overridden on the command line; defaults are set here.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 2
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

package io_bus_arbiter_pkg;

    localparam int ADDR_W = `IO_BUS_WIDTH_ADDR;
    localparam int CTRL_W = `IO_BUS_WIDTH_CTRL;
    localparam int DATA_W = `IO_BUS_WIDTH_DATA;

    localparam logic [CTRL_W-1:0] CTRL_NOP   = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] CTRL_WRITE = CTRL_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_write(input logic [CTRL_W-1:0] ctrl);
        return ctrl == CTRL_WRITE;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_picker.sv
// Combinational round-robin selection: the master at ptr has top priority,
// priority falls with increasing index modulo NUM_REQ.
module io_bus_arbiter_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    always_comb begin
        int k;
        logic [IDX_W-1:0] k_idx;
        any     = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            k_idx = IDX_W'(k);
            if (!any && req[k_idx]) begin
                any     = 1'b1;
                win_idx = k_idx;
            end
        end
        win_oh = any ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ masters a single bus transaction (IDLE/BUSY/DONE).
// Define IO_ARB_TIMEOUT_EN to add a BUSY watchdog that ends a stalled transfer with err=1.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*`IO_BUS_WIDTH_ADDR-1:0] m_addr,
    input  logic [NUM_REQ*`IO_BUS_WIDTH_CTRL-1:0] m_ctrl,
    input  logic [NUM_REQ*`IO_BUS_WIDTH_DATA-1:0] m_wdata,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [NUM_REQ-1:0]                    done,
    output logic [`IO_BUS_WIDTH_DATA-1:0]         rdata,
    output logic                                  err,
    output logic [`IO_BUS_WIDTH_ADDR-1:0]         bus_addr,
    output logic [`IO_BUS_WIDTH_CTRL-1:0]         bus_ctrl,
    output logic [`IO_BUS_WIDTH_DATA-1:0]         bus_wdata,
    output logic                                  bus_data_oe,
    input  logic [`IO_BUS_WIDTH_DATA-1:0]         bus_rdata,
    input  logic                                  bus_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("io_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("io_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [CTRL_W-1:0] ctrl_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr[g*ADDR_W +: ADDR_W];
        assign ctrl_arr[g]  = m_ctrl[g*CTRL_W +: CTRL_W];
        assign wdata_arr[g] = m_wdata[g*DATA_W +: DATA_W];
    end

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic [NUM_REQ-1:0] win_oh;
    logic [CTRL_W-1:0]  ctrl_lat;
    logic               pick_any;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               take_req, ack_hit, tmo_fire, tmo_hit;

    io_bus_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) rr_picker (
        .req     (req),
        .ptr     (ptr),
        .any     (pick_any),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_comb begin
        state_nxt   = state;
        take_req    = 1'b0;
        ack_hit     = 1'b0;
        tmo_fire    = 1'b0;
        gnt         = '0;
        done        = '0;
        bus_ctrl    = CTRL_NOP;
        bus_data_oe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    take_req  = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                gnt         = win_oh;
                bus_ctrl    = ctrl_lat;
                bus_data_oe = is_write(ctrl_lat);
                // ack has priority over a timeout landing in the same cycle
                if (bus_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt       = win_oh;
                done      = win_oh;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win       <= '0;
            win_oh    <= '0;
            ctrl_lat  <= CTRL_NOP;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (take_req) begin
                win       <= pick_idx;
                win_oh    <= pick_oh;
                ctrl_lat  <= ctrl_arr[pick_idx];
                bus_addr  <= addr_arr[pick_idx];
                bus_wdata <= wdata_arr[pick_idx];
            end
            if (ack_hit) begin
                rdata <= bus_rdata;
            end else if (tmo_fire) begin
                rdata <= '0;
            end
            // the finished master drops to lowest priority
            if (state == ST_DONE) begin
                ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    assign tmo_hit = (state == ST_BUSY) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (take_req) begin
                tmo_cnt <= '0;
            end else if (state == ST_BUSY && !bus_ack) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (ack_hit) begin
                err_q <= 1'b0;
            end else if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter against a transaction-level round-robin model.
// Build with IO_ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    localparam int N = 3;
`ifdef IO_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    localparam logic [CTRL_W-1:0] C_READ  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_WRITE = CTRL_W'(2);

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] m_addr;
    logic [N*CTRL_W-1:0] m_ctrl;
    logic [N*DATA_W-1:0] m_wdata;
    logic [N-1:0]        gnt, done;
    logic [DATA_W-1:0]   rdata, bus_wdata, bus_rdata;
    logic [ADDR_W-1:0]   bus_addr;
    logic [CTRL_W-1:0]   bus_ctrl;
    logic                err, bus_data_oe, bus_ack;

    logic [ADDR_W-1:0] ma [N];
    logic [CTRL_W-1:0] mc [N];
    logic [DATA_W-1:0] mw [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign m_addr[g*ADDR_W +: ADDR_W]  = ma[g];
        assign m_ctrl[g*CTRL_W +: CTRL_W]  = mc[g];
        assign m_wdata[g*DATA_W +: DATA_W] = mw[g];
    end

    io_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .m_addr(m_addr), .m_ctrl(m_ctrl), .m_wdata(m_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .err(err), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl),
        .bus_wdata(bus_wdata), .bus_data_oe(bus_data_oe), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // transaction-level model state
    int                exp_ptr;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;

    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        int order[$];
        for (int i = 0; i < N; i++) order.push_back((p + i) % N);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_masters();
        for (int k = 0; k < N; k++) begin
            ma[k] = $urandom;
            mw[k] = $urandom;
            mc[k] = CTRL_W'($urandom_range(0, 3));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; bus_ack = 1'b0; bus_rdata = '0;
        tick();
        rst = 1'b0;
        exp_ptr = 0; exp_rdata = '0; exp_err = 1'b0;
    endtask

    // One full transaction from IDLE: d ack-less BUSY cycles, then ack.
    // mode 0 holds req, 1 scrambles req and master inputs during BUSY, 2 drops req.
    task automatic run_txn(input logic [N-1:0] reqv, input int d, input logic [DATA_W-1:0] rd,
                           input int mode, output logic [N-1:0] seen);
        int w;
        logic [N-1:0] oh;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ew;
        logic [CTRL_W-1:0] ec;
        req = reqv; bus_ack = 1'b0;
        w  = ref_pick(reqv, exp_ptr);
        oh = N'(1) << w;
        ea = ma[w]; ew = mw[w]; ec = mc[w];
        tick();
        seen = gnt;
        for (int i = 0; i <= d; i++) begin
            n_checks++;
            if ({gnt, done, bus_ctrl, bus_data_oe, err} !== {oh, N'(0), ec, ec == C_WRITE, exp_err})
                $display("FAIL busy_ctl cyc%0d: got gnt=%b done=%b ctrl=%h oe=%b err=%b want gnt=%b ctrl=%h",
                         i, gnt, done, bus_ctrl, bus_data_oe, err, oh, ec);
            else n_pass++;
            n_checks++;
            if ({bus_addr, bus_wdata, rdata} !== {ea, ew, exp_rdata})
                $display("FAIL busy_lat cyc%0d: got addr=%h wdata=%h rdata=%h want %h %h %h",
                         i, bus_addr, bus_wdata, rdata, ea, ew, exp_rdata);
            else n_pass++;
            if (mode == 1) begin req = N'($urandom); rand_masters(); end
            if (mode == 2) req = '0;
            bus_ack   = (i == d);
            bus_rdata = (i == d) ? rd : DATA_W'($urandom);
            tick();
        end
        bus_ack = 1'b0; bus_rdata = $urandom;
        exp_ptr = (w + 1) % N; exp_rdata = rd; exp_err = 1'b0;
        n_checks++;
        if ({done, gnt, bus_ctrl, bus_data_oe, err, rdata} !== {oh, oh, CTRL_NOP, 1'b0, 1'b0, rd})
            $display("FAIL done_cyc: got done=%b gnt=%b ctrl=%h oe=%b err=%b rdata=%h want done=gnt=%b rdata=%h",
                     done, gnt, bus_ctrl, bus_data_oe, err, rdata, oh, rd);
        else n_pass++;
        tick();
        n_checks++;
        if ({gnt, done, bus_ctrl, bus_data_oe, rdata, bus_addr, bus_wdata} !==
            {N'(0), N'(0), CTRL_NOP, 1'b0, rd, ea, ew})
            $display("FAIL idle_hold: got gnt=%b done=%b ctrl=%h oe=%b rdata=%h addr=%h wdata=%h want rdata=%h addr=%h wdata=%h",
                     gnt, done, bus_ctrl, bus_data_oe, rdata, bus_addr, bus_wdata, rd, ea, ew);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; bus_ack = 1'b1; bus_rdata = $urandom;
        rand_masters();
        tick(); tick();
        n_checks++;
        if ({gnt, done, err, bus_ctrl, bus_data_oe, rdata, bus_addr, bus_wdata} !== '0)
            $display("FAIL reset_state: got gnt=%b done=%b err=%b ctrl=%h oe=%b rdata=%h addr=%h wdata=%h want all 0",
                     gnt, done, err, bus_ctrl, bus_data_oe, rdata, bus_addr, bus_wdata);
        else n_pass++;
        rst = 1'b0; req = '0; bus_ack = 1'b0;
        exp_ptr = 0; exp_rdata = '0; exp_err = 1'b0;
        tick();
        n_checks++;
        if ({gnt, done} !== '0) $display("FAIL reset_idle: got gnt=%b done=%b want 0", gnt, done);
        else n_pass++;
    endtask

    task automatic test_single_read();
        logic [N-1:0] seen;
        apply_reset();
        rand_masters();
        mc[0] = C_READ;
        run_txn(3'b001, 2, 32'h0000_00A5, 0, seen);
        n_checks++;
        if ({seen, rdata, err} !== {3'b001, 32'h0000_00A5, 1'b0})
            $display("FAIL single_read: got gnt=%b rdata=%h err=%b want 001 000000a5 0", seen, rdata, err);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_contention();
        int order[6] = '{0, 1, 2, 0, 1, 2};
        logic [N-1:0] seen;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rand_masters();
            run_txn(3'b111, 0, DATA_W'($urandom), 0, seen);
            n_checks++;
            if (seen !== (N'(1) << order[i]))
                $display("FAIL contention_order #%0d: got gnt=%b want master %0d", i, seen, order[i]);
            else n_pass++;
        end
        req = '0;
    endtask

    task automatic test_write();
        logic [N-1:0] seen;
        rand_masters();
        ma[2] = 32'hFFFF_F060; mw[2] = 32'h0000_00FF; mc[2] = C_WRITE;
        run_txn(3'b100, 1, DATA_W'($urandom), 0, seen);
        n_checks++;
        if ({seen, bus_addr, bus_wdata, bus_data_oe} !== {3'b100, 32'hFFFF_F060, 32'h0000_00FF, 1'b0})
            $display("FAIL write: got gnt=%b addr=%h wdata=%h oe=%b want 100 fffff060 000000ff 0",
                     seen, bus_addr, bus_wdata, bus_data_oe);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_stray_ack_and_drop();
        logic [N-1:0] seen;
        req = '0;
        for (int i = 0; i < 3; i++) begin
            bus_ack = 1'b1; bus_rdata = $urandom;
            tick();
            n_checks++;
            if ({gnt, done, bus_ctrl, rdata} !== {N'(0), N'(0), CTRL_NOP, exp_rdata})
                $display("FAIL stray_ack: got gnt=%b done=%b ctrl=%h rdata=%h want rdata=%h",
                         gnt, done, bus_ctrl, rdata, exp_rdata);
            else n_pass++;
        end
        bus_ack = 1'b0;
        rand_masters();
        run_txn(3'b010, 2, DATA_W'($urandom), 2, seen);
        n_checks++;
        if (seen !== (N'(1) << ((exp_ptr + N - 1) % N)))
            $display("FAIL dropped_req: got gnt=%b want winner %0d", seen, (exp_ptr + N - 1) % N);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_random_txns();
        logic [N-1:0] seen;
        for (int t = 0; t < 40; t++) begin
            rand_masters();
            run_txn(N'($urandom_range(1, 7)), $urandom_range(0, 3), DATA_W'($urandom), t % 3, seen);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_busy();
        logic [N-1:0] seen;
        apply_reset();
        rand_masters();
        req = 3'b110;
        tick(); tick();
        n_checks++;
        if (gnt !== 3'b010) $display("FAIL rst_mid_pre: got gnt=%b want 010", gnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({gnt, done, bus_ctrl, bus_data_oe} !== '0)
            $display("FAIL rst_mid: got gnt=%b done=%b ctrl=%h oe=%b want 0", gnt, done, bus_ctrl, bus_data_oe);
        else n_pass++;
        rst = 1'b0;
        exp_ptr = 0; exp_rdata = '0; exp_err = 1'b0;
        run_txn(3'b111, 0, DATA_W'($urandom), 0, seen);
        n_checks++;
        if (seen !== 3'b001) $display("FAIL rst_mid_ptr: got gnt=%b want 001", seen);
        else n_pass++;
        req = '0;
    endtask

`ifdef IO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N-1:0] seen;
        apply_reset();
        rand_masters();
        run_txn(3'b001, 0, 32'hDEAD_BEEF, 0, seen);
        req = 3'b010; bus_ack = 1'b0;
        tick();
        for (int i = 0; i < TMO; i++) begin
            n_checks++;
            if ({gnt, done} !== {3'b010, 3'b000})
                $display("FAIL tmo_busy cyc%0d: got gnt=%b done=%b want 010 000", i, gnt, done);
            else n_pass++;
            bus_rdata = $urandom;
            tick();
        end
        n_checks++;
        if ({done, err, rdata} !== {3'b010, 1'b1, 32'h0})
            $display("FAIL tmo_done: got done=%b err=%b rdata=%h want 010 1 0", done, err, rdata);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if ({gnt, err, rdata} !== {3'b000, 1'b1, 32'h0})
            $display("FAIL tmo_hold: got gnt=%b err=%b rdata=%h want 000 1 0", gnt, err, rdata);
        else n_pass++;
        exp_ptr = 2; exp_rdata = '0; exp_err = 1'b1;
        rand_masters();
        run_txn(3'b100, TMO - 1, 32'h1234_5678, 0, seen);
        n_checks++;
        if ({seen, err, rdata} !== {3'b100, 1'b0, 32'h1234_5678})
            $display("FAIL tmo_ack_wins: got gnt=%b err=%b rdata=%h want 100 0 12345678", seen, err, rdata);
        else n_pass++;
    endtask
`else
    task automatic test_no_timeout();
        logic [N-1:0] seen;
        apply_reset();
        rand_masters();
        run_txn(3'b001, 299, 32'h0BAD_F00D, 0, seen);
        n_checks++;
        if ({seen, err} !== {3'b001, 1'b0})
            $display("FAIL long_wait: got gnt=%b err=%b want 001 0", seen, err);
        else n_pass++;
        req = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; bus_ack = 1'b0; bus_rdata = '0;
        rand_masters();
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_stray_ack_and_drop();
        test_random_txns();
        test_reset_mid_busy();
`ifdef IO_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
